// File: rtl/audio_i2s_tx_if.sv
// Sample-source side of the I2S transmitter: one stereo pair per strobe,
// plus the once-per-frame request back to the producer.
interface audio_i2s_tx_if #(
    parameter int AUD_BIT_DEPTH = 24
);
    logic [AUD_BIT_DEPTH-1:0] lsound_in;
    logic [AUD_BIT_DEPTH-1:0] rsound_in;
    logic                     sample_strobe;
    logic                     sample_req;

    // Producer of samples (synthesizer core)
    modport master (
        output lsound_in,
        output rsound_in,
        output sample_strobe,
        input  sample_req
    );

    // Consumer of samples (transmitter)
    modport slave (
        input  lsound_in,
        input  rsound_in,
        input  sample_strobe,
        output sample_req
    );
endinterface

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: double-buffered stereo serial audio transmitter.
// Generates BCLK/LRCK from AUDIO_CLK, shifts {L,pad,R,pad} MSB-first,
// requests one pair per frame and flags underrun/overrun (sticky).
// Build option: define AUD_LJ_FORMAT_EN for left-justified framing;
// default (undefined) is I2S with data delayed one BCLK after LRCK.
module audio_i2s_tx #(
    parameter int AUD_BIT_DEPTH = 24,
    parameter int SLOT_BITS     = 32,
    parameter int BCLK_DIV      = 2
) (
    input  logic          AUDIO_CLK,
    input  logic          reset,
    audio_i2s_tx_if.slave aud,
    input  logic          clear_flags,
    output logic          AUD_BCLK,
    output logic          AUD_DACLRCK,
    output logic          AUD_DACDAT,
    output logic          underrun,
    output logic          overrun
);
    localparam int FRAME = 2 * SLOT_BITS;
    localparam int PW    = $clog2(FRAME);
    localparam int DW    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DW-1:0]            r_div_cnt;
    logic                     r_bclk;
    logic [PW-1:0]            r_pos;
    logic                     r_lrck;
    logic [FRAME-1:0]         r_shift;
    logic [AUD_BIT_DEPTH-1:0] r_hold_l;
    logic [AUD_BIT_DEPTH-1:0] r_hold_r;
    logic                     r_full;
    logic                     r_req;
    logic                     r_under;
    logic                     r_over;

    logic                     w_div_tc;
    logic                     w_fall;
    logic                     w_wrap;
    logic [PW-1:0]            w_pos_nxt;
    logic                     w_set_under;
    logic                     w_set_over;

    // Place each channel MSB-aligned in its slot; the slot tail stays zero.
    function automatic logic [FRAME-1:0] f_pack(input logic [AUD_BIT_DEPTH-1:0] l,
                                                input logic [AUD_BIT_DEPTH-1:0] r);
        logic [FRAME-1:0] f;
        f = '0;
        f[FRAME-1 -: AUD_BIT_DEPTH]     = l;
        f[SLOT_BITS-1 -: AUD_BIT_DEPTH] = r;
        return f;
    endfunction

    assign w_div_tc    = (r_div_cnt == DW'(BCLK_DIV - 1));
    assign w_fall      = w_div_tc & r_bclk;
    assign w_wrap      = w_fall & (r_pos == PW'(FRAME - 1));
    assign w_pos_nxt   = w_wrap ? '0 : r_pos + PW'(1);
    // Frame load with nothing pending and nothing arriving: send silence.
    assign w_set_under = w_wrap & ~r_full & ~aud.sample_strobe;
    // A load in the same cycle drains the old pair, so nothing is lost then.
    assign w_set_over  = ~w_wrap & aud.sample_strobe & r_full;

    // Bit-clock divider: toggle BCLK every BCLK_DIV cycles.
    always_ff @(posedge AUDIO_CLK or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_div_tc) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
        end
    end

    // Frame position and word clock, both advanced on BCLK falling edges.
    always_ff @(posedge AUDIO_CLK or posedge reset) begin
        if (reset) begin
            r_pos  <= '0;
            r_lrck <= 1'b0;
        end else if (w_fall) begin
            r_pos  <= w_pos_nxt;
            r_lrck <= (w_pos_nxt >= PW'(SLOT_BITS));
        end
    end

    // Holding buffer and frame shifter; frame load drains holding or bypasses.
    always_ff @(posedge AUDIO_CLK or posedge reset) begin
        if (reset) begin
            r_shift  <= '0;
            r_hold_l <= '0;
            r_hold_r <= '0;
            r_full   <= 1'b0;
            r_req    <= 1'b0;
        end else begin
            r_req <= w_wrap;
            if (w_wrap) begin
                if (r_full) begin
                    r_shift <= f_pack(r_hold_l, r_hold_r);
                    if (aud.sample_strobe) begin
                        r_hold_l <= aud.lsound_in;
                        r_hold_r <= aud.rsound_in;
                    end else begin
                        r_full <= 1'b0;
                    end
                end else if (aud.sample_strobe) begin
                    r_shift <= f_pack(aud.lsound_in, aud.rsound_in);
                end else begin
                    r_shift <= '0;
                end
            end else begin
                if (w_fall)
                    r_shift <= {r_shift[FRAME-2:0], 1'b0};
                if (aud.sample_strobe) begin
                    r_hold_l <= aud.lsound_in;
                    r_hold_r <= aud.rsound_in;
                    r_full   <= 1'b1;
                end
            end
        end
    end

    // Sticky status flags; a coincident set beats the clear.
    always_ff @(posedge AUDIO_CLK or posedge reset) begin
        if (reset) begin
            r_under <= 1'b0;
            r_over  <= 1'b0;
        end else begin
            if (w_set_under)      r_under <= 1'b1;
            else if (clear_flags) r_under <= 1'b0;
            if (w_set_over)       r_over  <= 1'b1;
            else if (clear_flags) r_over  <= 1'b0;
        end
    end

`ifdef AUD_LJ_FORMAT_EN
    // Left-justified: shifter MSB is already a register updated on BCLK fall.
    assign AUD_DACDAT = r_shift[FRAME-1];
`else
    logic r_dat;

    // I2S: one extra BCLK of delay so data trails the LRCK transition.
    always_ff @(posedge AUDIO_CLK or posedge reset) begin
        if (reset)
            r_dat <= 1'b0;
        else if (w_fall)
            r_dat <= r_shift[FRAME-1];
    end

    assign AUD_DACDAT = r_dat;
`endif

    assign AUD_BCLK       = r_bclk;
    assign AUD_DACLRCK    = r_lrck;
    assign aud.sample_req = r_req;
    assign underrun       = r_under;
    assign overrun        = r_over;
endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: cycle-count reference model (frame bit vector
// indexed by position derived from elapsed clocks) compared every cycle.
module tb_audio_i2s_tx;
    localparam int W  = 24;
    localparam int S  = 32;
    localparam int D  = 2;
    localparam int FR = 2 * S;
    localparam int FRAME_CYC = 4 * D * S;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    logic bclk, lrck, dat, under, over;

    audio_i2s_tx_if #(.AUD_BIT_DEPTH(W)) aud();

    audio_i2s_tx #(.AUD_BIT_DEPTH(W), .SLOT_BITS(S), .BCLK_DIV(D)) dut (
        .AUDIO_CLK   (clk),
        .reset       (rst),
        .aud         (aud),
        .clear_flags (clr),
        .AUD_BCLK    (bclk),
        .AUD_DACLRCK (lrck),
        .AUD_DACDAT  (dat),
        .underrun    (under),
        .overrun     (over)
    );

    always #5 clk = ~clk;

    logic [5:0] obs;
    assign obs = {bclk, lrck, dat, aud.sample_req, under, over};

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          m_k;
    bit          m_full;
    logic [W-1:0] m_hl, m_hr;
    logic [FR-1:0] m_frame;
    bit          m_under, m_over, m_req, m_lj, m_dat;

    function automatic logic [FR-1:0] pack(input logic [W-1:0] l, input logic [W-1:0] r);
        logic [FR-1:0] f;
        f = '0;
        f[FR-1 -: W] = l;
        f[S-1 -: W]  = r;
        return f;
    endfunction

    function automatic logic [5:0] exp_out();
        logic eb, el, ed;
        eb = ((m_k / D) % 2) == 1;
        el = ((m_k / (2 * D)) % FR) >= S;
`ifdef AUD_LJ_FORMAT_EN
        ed = m_lj;
`else
        ed = m_dat;
`endif
        return {eb, el, ed, m_req, m_under, m_over};
    endfunction

    function automatic bit load_next();
        int k;
        k = m_k + 1;
        return (k % (2 * D) == 0) && ((k / (2 * D)) % FR == 0);
    endfunction

    task automatic model_reset();
        m_k = 0; m_full = 0; m_hl = '0; m_hr = '0; m_frame = '0;
        m_under = 0; m_over = 0; m_req = 0; m_lj = 0; m_dat = 0;
    endtask

    // Drive one cycle of inputs, advance the model by one clock edge.
    task automatic step(input bit stb, input logic [W-1:0] l, input logic [W-1:0] r, input bit c);
        bit fall, load, su, so;
        int p;
        aud.sample_strobe = stb;
        aud.lsound_in = l;
        aud.rsound_in = r;
        clr = c;
        @(posedge clk);
        m_k++;
        fall = (m_k % (2 * D)) == 0;
        p    = (m_k / (2 * D)) % FR;
        load = fall && (p == 0);
        su = 0; so = 0;
        if (load) begin
            if (m_full) begin
                m_frame = pack(m_hl, m_hr);
                if (stb) begin m_hl = l; m_hr = r; end
                else m_full = 0;
            end else if (stb) begin
                m_frame = pack(l, r);
            end else begin
                m_frame = '0;
                su = 1;
            end
        end else if (stb) begin
            if (m_full) so = 1;
            m_hl = l; m_hr = r; m_full = 1;
        end
        if (c) begin m_under = 0; m_over = 0; end
        if (su) m_under = 1;
        if (so) m_over = 1;
        m_req = load;
        if (fall) begin
            m_dat = m_lj;
            m_lj  = m_frame[FR-1-p];
        end
        #1;
        aud.sample_strobe = 1'b0;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0;
        aud.sample_strobe = 1'b0; aud.lsound_in = '0; aud.rsound_in = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (obs !== 6'b000000) begin
            fails++;
            $display("FAIL reset_outputs got %b exp %b", obs, 6'b000000);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_idle();
        int lr_hi = 0, rises = 0;
        logic pb = 1'b0;
        for (int i = 0; i < FRAME_CYC + 8; i++) begin
            step(0, '0, '0, 0);
            tests++;
            if (obs !== exp_out()) begin
                fails++;
                $display("FAIL idle k=%0d got %b exp %b", m_k, obs, exp_out());
            end
            if (i < FRAME_CYC) begin
                if (lrck === 1'b1) lr_hi++;
                if (bclk === 1'b1 && pb === 1'b0) rises++;
                pb = bclk;
            end
            if (i == FRAME_CYC - 1) begin
                tests++;
                if ({aud.sample_req, under, dat} !== 3'b110) begin
                    fails++;
                    $display("FAIL first_wrap got req/under/dat=%b exp 110", {aud.sample_req, under, dat});
                end
            end
        end
        tests++;
        if (lr_hi != FRAME_CYC / 2) begin
            fails++;
            $display("FAIL lrck_high_cycles got %0d exp %0d", lr_hi, FRAME_CYC / 2);
        end
        tests++;
        if (rises != FRAME_CYC / (2 * D)) begin
            fails++;
            $display("FAIL bclk_periods got %0d exp %0d", rises, FRAME_CYC / (2 * D));
        end
    endtask

    task automatic test_clear();
        step(0, '0, '0, 1);
        tests++;
        if (obs !== exp_out() || under !== 1'b0) begin
            fails++;
            $display("FAIL clear_under got %b exp %b", obs, exp_out());
        end
    endtask

    task automatic test_pattern();
        int ld = -1;
        bit isld;
        step(1, 24'h800001, 24'h7FFFFE, 0);
        for (int i = 0; i < 2 * FRAME_CYC + 16; i++) begin
            isld = load_next();
            step(0, '0, '0, 0);
            tests++;
            if (obs !== exp_out()) begin
                fails++;
                $display("FAIL pattern k=%0d got %b exp %b", m_k, obs, exp_out());
            end
            if (isld && ld < 0) begin
                ld = i;
                tests++;
`ifdef AUD_LJ_FORMAT_EN
                if ({lrck, dat} !== 2'b01) begin
`else
                if ({lrck, dat} !== 2'b00) begin
`endif
                    fails++;
                    $display("FAIL load_edge_msb got lrck/dat=%b", {lrck, dat});
                end
            end
            if (ld >= 0 && i == ld + 2 * D) begin
                tests++;
                if (dat !== 1'b1) begin
                    fails++;
                    $display("FAIL left_msb_next_bclk got %b exp 1", dat);
                end
            end
        end
    endtask

    task automatic test_overrun();
        logic [W-1:0] a, b;
        while (m_k % FRAME_CYC != 10) step(0, '0, '0, 0);
        a = W'($urandom); b = W'($urandom);
        step(1, a, b, 1);
        repeat (10) step(0, '0, '0, 0);
        a = W'($urandom); b = W'($urandom);
        step(1, a, b, 0);
        tests++;
        if (over !== 1'b1 || obs !== exp_out()) begin
            fails++;
            $display("FAIL overrun_set got %b exp %b", obs, exp_out());
        end
        step(0, '0, '0, 1);
        tests++;
        if (over !== 1'b0 || obs !== exp_out()) begin
            fails++;
            $display("FAIL overrun_clear got %b exp %b", obs, exp_out());
        end
        for (int i = 0; i < FRAME_CYC + 2 * D * S; i++) begin
            step(0, '0, '0, 0);
            tests++;
            if (obs !== exp_out()) begin
                fails++;
                $display("FAIL overrun_tx k=%0d got %b exp %b", m_k, obs, exp_out());
            end
        end
    endtask

    task automatic test_bypass();
        int guard = 0;
        while (!(load_next() && !m_full) && guard < 3 * FRAME_CYC) begin
            step(0, '0, '0, 1);
            guard++;
        end
        tests++;
        if (guard >= 3 * FRAME_CYC) begin
            fails++;
            $display("FAIL bypass_reach_load got timeout exp load");
        end
        step(1, W'($urandom), W'($urandom), 0);
        tests++;
        if ({aud.sample_req, under} !== 2'b10 || obs !== exp_out()) begin
            fails++;
            $display("FAIL bypass_load got %b exp %b", obs, exp_out());
        end
        for (int i = 0; i < FRAME_CYC; i++) begin
            step(0, '0, '0, 0);
            tests++;
            if (obs !== exp_out()) begin
                fails++;
                $display("FAIL bypass_tx k=%0d got %b exp %b", m_k, obs, exp_out());
            end
        end
        tests++;
        if ({aud.sample_req, under} !== 2'b11) begin
            fails++;
            $display("FAIL bypass_left_empty got req/under=%b exp 11", {aud.sample_req, under});
        end
    endtask

    task automatic test_full_load_strobe();
        while (m_k % FRAME_CYC != 100) step(0, '0, '0, 1);
        step(1, W'($urandom), W'($urandom), 0);
        while (!load_next()) step(0, '0, '0, 0);
        step(1, W'($urandom), W'($urandom), 0);
        tests++;
        if (over !== 1'b0 || obs !== exp_out()) begin
            fails++;
            $display("FAIL full_load_strobe got %b exp %b", obs, exp_out());
        end
        for (int i = 0; i < 2 * FRAME_CYC + 8; i++) begin
            step(0, '0, '0, 0);
            tests++;
            if (obs !== exp_out()) begin
                fails++;
                $display("FAIL full_load_tx k=%0d got %b exp %b", m_k, obs, exp_out());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4 * FRAME_CYC; i++) begin
            step($urandom_range(0, 119) == 0, W'($urandom), W'($urandom),
                 $urandom_range(0, 49) == 0);
            tests++;
            if (obs !== exp_out()) begin
                fails++;
                $display("FAIL random k=%0d got %b exp %b", m_k, obs, exp_out());
            end
        end
    endtask

    task automatic test_midreset();
        int n = 0;
        while (m_k % FRAME_CYC != 40 * 2 * D + 1) step(0, '0, '0, 0);
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if (obs !== 6'b000000) begin
            fails++;
            $display("FAIL async_reset got %b exp 000000", obs);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        while (n < 2 * FRAME_CYC) begin
            step(0, '0, '0, 0);
            n++;
            tests++;
            if (obs !== exp_out()) begin
                fails++;
                $display("FAIL post_reset k=%0d got %b exp %b", m_k, obs, exp_out());
            end
            if (aud.sample_req === 1'b1) break;
        end
        tests++;
        if (n != FRAME_CYC) begin
            fails++;
            $display("FAIL post_reset_req got %0d cycles exp %0d", n, FRAME_CYC);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle();
        test_clear();
        test_pattern();
        test_overrun();
        test_bypass();
        test_full_load_strobe();
        test_random();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Serial audio transmitter downstream of the synthesizer core's stereo sample outputs (lsound_out / rsound_out). It runs on the audio clock domain and double-buffers one stereo sample pair. It generates the DAC bit clock and LR clock, and shifts each pair out MSB-first in I2S or left-justified framing. It requests the next pair once per frame and flags underrun and overrun.

## Interface
- AUD_BIT_DEPTH, 24, sample width per channel.
- SLOT_BITS, 32, BCLK periods per channel slot; AUD_BIT_DEPTH <= SLOT_BITS <= 32.
- BCLK_DIV, 2, AUDIO_CLK cycles per BCLK half-period; >= 1.

Ports:
- AUDIO_CLK  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- lsound_in  in  AUD_BIT_DEPTH  left sample, two's complement.
- rsound_in  in  AUD_BIT_DEPTH  right sample.
- sample_strobe  in  1  1-cycle pulse: both inputs valid this cycle.
- clear_flags  in  1  clears the sticky flags.
- sample_req  out  1  1-cycle pulse at each frame load.
- AUD_BCLK  out  1  bit clock.
- AUD_DACLRCK  out  1  0 = left slot, 1 = right slot.
- AUD_DACDAT  out  1  serial data.
- underrun  out  1  sticky: frame loaded with no pending sample.
- overrun  out  1  sticky: strobe overwrote an unsent pending sample.

## Operation
- Divider: div_cnt counts 0..BCLK_DIV-1. At terminal count it wraps and AUD_BCLK toggles.
- Falling-edge event: the cycle where AUD_BCLK goes 1->0. Frame position p (0..2*SLOT_BITS-1) increments on each falling-edge event and wraps to 0.
- AUD_DACLRCK = (p >= SLOT_BITS), registered and updated with p.
- Holding buffer: {L,R} plus a full flag. sample_strobe writes both channels and sets full. If full was already set and no frame load occurs in the same cycle, overrun is set.
- Frame load happens on the falling-edge event where p wraps to 0. The 2*SLOT_BITS shift register loads {L, zero-pad, R, zero-pad}, where each zero-pad is SLOT_BITS-AUD_BIT_DEPTH bits. A 1-cycle sample_req pulse is issued.
  - Source full: load the holding contents and clear full.
  - Source empty, strobe in the same cycle: bypass, loading the strobe data directly; full stays 0.
  - Source empty, no strobe: load all zeros and set underrun.
  - Full and strobe in the same cycle: old holding contents go to the shifter, new data goes to holding, full stays 1, no overrun.
- Shift: on each falling-edge event that is not a load, shift left by one. The shifter MSB drives the data path.
- clear_flags clears underrun/overrun. If a set condition coincides with clear_flags, the set wins.

## Timing
- Reset values: AUD_BCLK=0, AUD_DACLRCK=0, AUD_DACDAT=0, sample_req=0, underrun=0, overrun=0.
- Internal reset state: p=0, div_cnt=0, shifter=0, full=0.
- Reset mid-frame aborts immediately. The first post-reset frame load occurs at the first wrap of p to 0, i.e. after 2*SLOT_BITS falling edges.
- Frame period is 4*BCLK_DIV*SLOT_BITS AUDIO_CLK cycles.
- All outputs are registered and change only on falling-edge events, except sample_req and the flags, which are cycle-accurate to their triggering event.
- AUD_DACDAT changes 0 cycles after AUD_BCLK falls, so it is stable across the rising edge.
- Latency: a pending sample's left MSB appears on AUD_DACDAT at the frame-load edge (left-justified) or one BCLK later (I2S).

## Configuration
- AUD_LJ_FORMAT_EN defined: left-justified. AUD_DACDAT = shifter MSB, aligned with AUD_DACLRCK transitions.
- AUD_LJ_FORMAT_EN undefined (default): I2S.
  - AUD_DACDAT passes through one extra flop updated on falling-edge events, giving a 1-BCLK delay relative to AUD_DACLRCK.
  - The last right-slot bit appears at p=0 of the following frame.

## Test plan
- Reset, then idle with BCLK_DIV=2, SLOT_BITS=32 -> AUD_BCLK period 4 cycles; AUD_DACLRCK period 256 cycles with 128 low / 128 high. At the first wrap: sample_req pulse and underrun=1; AUD_DACDAT stays 0.
- Strobe L=24'h800001, R=24'h7FFFFE before a frame load, I2S -> AUD_DACLRCK falls; one BCLK later the left bits 1,0...0,1 appear, then 8 zeros. The right slot emits 0,1...1,0 followed by 8 zeros (the last zero spills into p=0).
- Same stimulus with AUD_LJ_FORMAT_EN -> left MSB=1 in the same BCLK as the AUD_DACLRCK fall.
- Two strobes within one frame -> overrun=1; the second pair is transmitted. Assert clear_flags -> overrun=0 next cycle.
- Strobe coincident with a frame-load cycle while holding is empty -> the bypassed pair is transmitted in that frame, with no underrun and full=0.
- Assert reset at p=40 -> all outputs 0 asynchronously. After release, the next sample_req occurs 256 cycles later.
